// File: rtl/sb_pkg.sv
// Shared types and widths for the keycode / volume event queue.
package sb_pkg;

    localparam int KC_W  = 16;
    localparam int VOL_W = 6;

    typedef logic [KC_W-1:0] sb_keycode_t;

    typedef struct packed {
        logic             mute;
        logic [VOL_W-1:0] l;
        logic [VOL_W-1:0] r;
    } sb_vol_t;

endpackage

// File: rtl/sb_sync_fifo.sv
// Show-ahead synchronous FIFO with a separate occupancy count and a
// one-cycle pulse when a push is dropped because the FIFO is full.
module sb_sync_fifo
    import sb_pkg::*;
#(
    parameter int W      = KC_W,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [W-1:0]      push_data,
    input  logic              pop,
    output logic [W-1:0]      head,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (ADDR_W+1)'(DEPTH));

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | pop);
    assign overflow = push & full & ~pop;

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/sb_keyevent_queue.sv
// CPU-facing event buffer: keycode FIFO, synchronized volume/mute snapshot
// with sticky change flag, sticky overflow flag and a level interrupt.
module sb_keyevent_queue
    import sb_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk27,
    input  logic               hw_reset_n,
    input  logic [KC_W-1:0]    latest_keycode,
    input  logic               latest_keycode_valid,
    input  logic [11:0]        volume_db,
    input  logic               is_muted,
    input  logic               volume_db_valid,
    input  logic               kc_pop,
    output logic [KC_W-1:0]    kc_data,
    output logic               kc_empty,
    output logic [ADDR_W:0]    kc_count,
    output logic               kc_overflow,
    input  logic               ovf_clr,
    output logic [VOL_W-1:0]   vol_l,
    output logic [VOL_W-1:0]   vol_r,
    output logic               vol_mute,
    output logic               vol_changed,
    input  logic               vol_ack,
    input  logic               irq_en,
    output logic               irq
);

    sb_keycode_t head;
    logic        drop;
    logic [2:0]  sync_reg;
    logic        vol_rise;
    sb_vol_t     vol_reg;
    logic        vol_changed_reg;
    logic        ovf_reg;
    logic        irq_reg;

    sb_sync_fifo #(
        .W      (KC_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk27),
        .rst_n     (hw_reset_n),
        .push      (latest_keycode_valid),
        .push_data (latest_keycode),
        .pop       (kc_pop),
        .head      (head),
        .empty     (kc_empty),
        .count     (kc_count),
        .overflow  (drop)
    );

    // Two flops of synchronization for the mon_clk strobe, third for edge detect.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], volume_db_valid};
        end
    end

    assign vol_rise = sync_reg[1] & ~sync_reg[2];

    // Snapshot the quasi-static volume/mute fields on the detected rise.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            vol_reg <= '0;
        end else if (vol_rise) begin
            vol_reg <= '{mute: is_muted, l: volume_db[11:6], r: volume_db[5:0]};
        end
    end

    // Sticky flags; a new event in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            vol_changed_reg <= 1'b0;
            ovf_reg         <= 1'b0;
        end else begin
            if (vol_rise) begin
                vol_changed_reg <= 1'b1;
            end else if (vol_ack) begin
                vol_changed_reg <= 1'b0;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Registered level interrupt, one cycle behind the flags it summarizes.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en & (~kc_empty | vol_changed_reg | ovf_reg);
        end
    end

    assign kc_data     = head;
    assign kc_overflow = ovf_reg;
    assign vol_l       = vol_reg.l;
    assign vol_r       = vol_reg.r;
    assign vol_mute    = vol_reg.mute;
    assign vol_changed = vol_changed_reg;
    assign irq         = irq_reg;

endmodule
